// File: rtl/multicycle_controller.sv
// Multi-cycle main control unit for the RV32 core.
// A Moore-style FSM walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
// Memory waits are bounded by a timeout that traps to FAULT, illegal opcodes
// also trap to FAULT, and every retired instruction bumps a wrapping counter.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | first cycle after reset, heads straight to FETCH
//   FETCH  | instruction read; IR and PC load once mem_ready arrives
//   DECODE | opcode captured into opc_q and checked for legality
//   EXEC   | ALU phase; branches retire here
//   MEM    | data read (LW) or write (SW), held until mem_ready
//   WB     | register file write from the ALU or from memory
//   FAULT  | sticky error, left only through reset
module multicycle_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode,
  input  logic             mem_ready,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [1:0]       ALUOp,
  output logic             Branch,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             Fault,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  // A zero TIMEOUT still needs a one-bit counter so the declaration stays legal.
  localparam int              WAIT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t             state_q, state_d;
  logic [6:0]         opc_q, opc_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               retire;
  logic               timeout_hit;
  logic               opc_legal;

  // Opcode legality check for the value currently presented in DECODE.
  always_comb begin
    opc_legal = (Opcode == OP_R)  || (Opcode == OP_I) || (Opcode == OP_LW) ||
                (Opcode == OP_SW) || (Opcode == OP_BR);
  end

  // The last permitted low cycle of a memory wait; a ready in the same cycle wins.
  always_comb begin
    timeout_hit = (TIMEOUT > 0) && !mem_ready && (wait_q == WAIT_LAST);
  end

  // Next-state, wait counter and retire logic. wait_d defaults to zero, which
  // clears it on entry to FETCH/MEM and on every ready cycle.
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    wait_d  = '0;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          wait_d = (TIMEOUT > 0) ? wait_q + 1'b1 : '0;
        end
      end
      S_DECODE: begin
        opc_d   = Opcode;
        state_d = opc_legal ? S_EXEC : S_FAULT;
      end
      S_EXEC: begin
        case (opc_q)
          OP_LW, OP_SW: state_d = S_MEM;
          OP_R, OP_I:   state_d = S_WB;
          OP_BR: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          default:      state_d = S_FAULT;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (opc_q == OP_LW) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          wait_d = (TIMEOUT > 0) ? wait_q + 1'b1 : '0;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
    cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
  end

  // State, captured opcode, wait counter and retire counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // Control decode from state and opc_q; only IRWrite/PCWrite look at mem_ready.
  always_comb begin
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUOp    = 2'b00;
    Branch   = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    Fault    = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_EXEC: begin
        ALUSrc = (opc_q == OP_LW) || (opc_q == OP_SW) || (opc_q == OP_I);
        Branch = (opc_q == OP_BR);
        if ((opc_q == OP_R) || (opc_q == OP_I)) begin
          ALUOp = 2'b10;
        end else if (opc_q == OP_BR) begin
          ALUOp = 2'b01;
        end
      end
      S_MEM: begin
        ALUSrc   = 1'b1;
        MemRead  = (opc_q == OP_LW);
        MemWrite = (opc_q == OP_SW);
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemtoReg = (opc_q == OP_LW);
      end
      S_FAULT: Fault = 1'b1;
      default: ;
    endcase
  end

  assign state_o     = state_q;
  assign instr_count = cnt_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle main control unit for the RV32 core. It replaces the single-cycle opcode decoder with a Moore-style FSM that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. It handles variable-latency memory through a ready handshake with a timeout, traps illegal opcodes, and counts retired instructions. It sits between the instruction register (Opcode source) and the datapath/memory control inputs.

Parameters:
TIMEOUT, 16, max consecutive cycles mem_ready may stay low in FETCH or MEM before FAULT; 0 disables the timeout
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
Opcode  input  7  instruction[6:0] from the instruction register; sampled in DECODE
mem_ready  input  1  memory completed the current read or write this cycle
ALUSrc  output  1  0: ALU operand B = rs2; 1: sign-extended immediate
MemtoReg  output  1  0: write-back from ALU; 1: from data memory
RegWrite  output  1  register file write enable
MemRead  output  1  memory read request (instruction fetch or LW)
MemWrite  output  1  memory write request (SW)
ALUOp  output  2  00: add (LW/SW); 01: branch compare; 10: R/I-type funct decode
Branch  output  1  PC takes branch target if ALU zero
IRWrite  output  1  load instruction register
PCWrite  output  1  PC <= PC+4
Fault  output  1  sticky error flag
state_o  output  3  current state encoding, for debug
instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Opcodes: R=0110011, I=0010011, LW=0000011, SW=0100011, BR=1100011. Any other value is illegal.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7.
- Reset, while asserted (asynchronous):
  - state=IDLE; opc_q=0; wait_cnt=0; instr_count=0.
  - All control outputs 0; Fault=0.
  - A reset asserted in any state, mid-instruction included, aborts the instruction with no retire.
- Outputs are decoded from state and opc_q only. The exceptions are IRWrite and PCWrite, which are also gated by mem_ready. Any output not listed for a state is 0.
- IDLE: next state FETCH, unconditionally.
- FETCH: MemRead=1.
  - If mem_ready=1: IRWrite=1 and PCWrite=1 in that same cycle; next state DECODE.
  - If mem_ready=0: stay in FETCH and wait_cnt++.
- DECODE: opc_q <= Opcode.
  - Legal opcode: next state EXEC.
  - Illegal opcode: next state FAULT.
- EXEC: ALUSrc=1 for LW/SW/I. ALUOp=10 for R/I, 01 for BR, 00 for LW/SW. Branch=1 for BR.
  - LW/SW: next state MEM.
  - R/I: next state WB.
  - BR: next state FETCH and retire.
- MEM: ALUSrc=1; ALUOp=00; MemRead=1 for LW; MemWrite=1 for SW. The request is held until mem_ready=1.
  - On mem_ready=1: LW goes to WB; SW goes to FETCH and retires.
  - If mem_ready=0: wait_cnt++.
- WB: RegWrite=1; MemtoReg=1 for LW, 0 for R/I; next state FETCH and retire.
- Retire: instr_count++ on every transition into FETCH from EXEC, MEM or WB. It wraps from all-ones to 0.
- Timeout (TIMEOUT>0):
  - wait_cnt clears on entry to FETCH or MEM and on any cycle with mem_ready=1.
  - If mem_ready=0 and wait_cnt==TIMEOUT-1, the next state is FAULT. In other words, TIMEOUT consecutive low cycles trigger FAULT.
  - mem_ready=1 in that same cycle wins; no fault.
- FAULT: Fault=1 and all other controls 0. Absorbing: only reset exits. instr_count is frozen.
- mem_ready is ignored outside FETCH and MEM.
- Counter widths: wait_cnt is $clog2(TIMEOUT+1) bits; instr_count is CNT_W bits.

Test Plan:
- R-type, mem_ready tied 1 after reset release → states 0,1,2,3,5,1. RegWrite=1 only in WB. ALUOp=10 in EXEC. instr_count 0→1 on entry to FETCH.
- LW with mem_ready low for 3 cycles in MEM → MEM held 4 cycles with MemRead=1. Then WB with MemtoReg=1 and RegWrite=1. Total 8 cycles FETCH-to-FETCH with 1-cycle fetch.
- SW then BEQ back-to-back, ready=1 → SW: MemWrite=1 in MEM, RegWrite never 1, 4 cycles. BEQ: Branch=1 and ALUOp=01 in EXEC, 3 cycles. instr_count=2.
- Opcode 1111111 in DECODE → FAULT next cycle, Fault=1, state_o=7. Stays there for 20 cycles despite mem_ready toggling. Reset returns to IDLE with Fault=0.
- TIMEOUT=4, mem_ready=0 throughout FETCH → FAULT after exactly 4 FETCH cycles. With mem_ready=1 on the 4th cycle instead → DECODE, no fault.
- Reset asserted mid-MEM of an SW → MemWrite drops in the same cycle (asynchronous), state_o=0, instr_count=0. CNT_W=4 with 17 retires → instr_count=1.
